// File: rtl/l2_home_pkg.sv
// Shared line geometry and Spandex message encodings for the L2 home responder.
// The line macros are guarded so a full L2 build can supply its own values.
`ifndef BITS_PER_WORD
`define BITS_PER_WORD 32
`endif
`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 4
`endif
`ifndef BITS_PER_LINE
`define BITS_PER_LINE 128
`endif

package l2_home_pkg;

  typedef logic [4:0]  mix_msg_t;
  typedef logic [1:0]  hprot_t;
  typedef logic [25:0] line_addr_t;
  typedef logic [3:0]  invack_cnt_t;

  localparam mix_msg_t REQ_V      = 5'h10;
  localparam mix_msg_t REQ_S      = 5'h11;
  localparam mix_msg_t REQ_O      = 5'h12;
  localparam mix_msg_t REQ_ODATA  = 5'h13;
  localparam mix_msg_t REQ_WT     = 5'h14;
  localparam mix_msg_t REQ_WB     = 5'h15;

  localparam mix_msg_t RSP_V      = 5'h08;
  localparam mix_msg_t RSP_S      = 5'h09;
  localparam mix_msg_t RSP_O      = 5'h0A;
  localparam mix_msg_t RSP_ODATA  = 5'h0B;
  localparam mix_msg_t RSP_WT     = 5'h0C;
  localparam mix_msg_t RSP_WB_ACK = 5'h0D;

endpackage

// File: rtl/l2_home_responder_if.sv
// Request-out / response-in channel pair between the L2 and its home node.
// master = the L2 side, slave = the home responder.
interface l2_home_responder_if;
  import l2_home_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  mix_msg_t                   req_coh_msg;
  hprot_t                     req_hprot;
  line_addr_t                 req_addr;
  logic [`BITS_PER_LINE-1:0]  req_line;
  logic [`WORDS_PER_LINE-1:0] req_word_mask;

  logic                       rsp_valid;
  logic                       rsp_ready;
  mix_msg_t                   rsp_coh_msg;
  line_addr_t                 rsp_addr;
  logic [`BITS_PER_LINE-1:0]  rsp_line;
  logic [`WORDS_PER_LINE-1:0] rsp_word_mask;
  invack_cnt_t                rsp_invack_cnt;

  modport master (
    output req_valid, req_coh_msg, req_hprot, req_addr, req_line, req_word_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_coh_msg, rsp_addr, rsp_line, rsp_word_mask, rsp_invack_cnt
  );

  modport slave (
    input  req_valid, req_coh_msg, req_hprot, req_addr, req_line, req_word_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_coh_msg, rsp_addr, rsp_line, rsp_word_mask, rsp_invack_cnt
  );
endinterface

// File: rtl/l2_home_responder.sv
// Stand-in LLC/directory for running the L2 standalone: one outstanding request,
// zero-initialised line store, fixed response latency.
module l2_home_responder
  import l2_home_pkg::*;
#(
  parameter int DEPTH_BITS = 6,
  parameter int LATENCY    = 4
) (
  input  logic               clk,
  input  logic               rst,
  l2_home_responder_if.slave bus,
  output logic               err_unsupported,
  output logic [15:0]        rsp_count
);

  localparam int ENTRIES = 1 << DEPTH_BITS;
  localparam int WB      = `BITS_PER_WORD;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t                     state, state_nxt;
  logic [DEPTH_BITS-1:0]      init_idx;
  logic [3:0]                 cnt;
  mix_msg_t                   cap_msg;
  hprot_t                     hprot_unused;
  line_addr_t                 cap_addr;
  logic [`BITS_PER_LINE-1:0]  cap_line;
  logic [`WORDS_PER_LINE-1:0] cap_mask;

  logic [`BITS_PER_LINE-1:0]  store [ENTRIES];
  logic [DEPTH_BITS-1:0]      idx;
  logic [`BITS_PER_LINE-1:0]  rd_line, wr_line;
  logic                       done, supported, is_write;
  mix_msg_t                   rsp_msg_nxt;

  assign idx     = cap_addr[DEPTH_BITS-1:0];
  assign rd_line = store[idx];
  // The action fires on the edge where the count reaches zero, so WAIT lasts LATENCY cycles.
  assign done    = (state == WAIT) && (cnt <= 4'd1);

  assign bus.req_ready      = (state == IDLE);
  assign bus.rsp_invack_cnt = '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    supported   = 1'b1;
    is_write    = 1'b0;
    rsp_msg_nxt = '0;
    case (cap_msg)
      REQ_V:     rsp_msg_nxt = RSP_V;
      REQ_S:     rsp_msg_nxt = RSP_S;
      REQ_O:     rsp_msg_nxt = RSP_O;
      REQ_ODATA: rsp_msg_nxt = RSP_ODATA;
      REQ_WT: begin
        rsp_msg_nxt = RSP_WT;
        is_write    = 1'b1;
      end
      REQ_WB: begin
        rsp_msg_nxt = RSP_WB_ACK;
        is_write    = 1'b1;
      end
      default:   supported = 1'b0;
    endcase
  end

  always_comb begin
    wr_line = rd_line;
    for (int w = 0; w < `WORDS_PER_LINE; w++) begin
      if (cap_mask[w]) wr_line[w*WB +: WB] = cap_line[w*WB +: WB];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: if (init_idx == '1) state_nxt = IDLE;
      IDLE: if (bus.req_valid) state_nxt = WAIT;
      WAIT: if (done) state_nxt = supported ? RESP : IDLE;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx          <= '0;
      cnt               <= '0;
      cap_msg           <= '0;
      hprot_unused      <= '0;
      cap_addr          <= '0;
      cap_line          <= '0;
      cap_mask          <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_coh_msg   <= '0;
      bus.rsp_addr      <= '0;
      bus.rsp_line      <= '0;
      bus.rsp_word_mask <= '0;
      err_unsupported   <= 1'b0;
      rsp_count         <= '0;
    end else begin
      case (state)
        INIT: init_idx <= init_idx + 1'b1;
        IDLE: if (bus.req_valid) begin
          cap_msg      <= bus.req_coh_msg;
          hprot_unused <= bus.req_hprot;
          cap_addr     <= bus.req_addr;
          cap_line     <= bus.req_line;
          cap_mask     <= bus.req_word_mask;
          cnt          <= 4'(LATENCY);
        end
        WAIT: begin
          if (!done) begin
            cnt <= cnt - 1'b1;
          end else if (supported) begin
            bus.rsp_valid     <= 1'b1;
            bus.rsp_coh_msg   <= rsp_msg_nxt;
            bus.rsp_addr      <= cap_addr;
            bus.rsp_line      <= is_write ? '0 : rd_line;
            bus.rsp_word_mask <= cap_mask;
          end else begin
            err_unsupported <= 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          rsp_count     <= rsp_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the store has no reset term; the INIT sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)          store[init_idx] <= '0;
      else if (done && is_write)  store[idx]      <= wr_line;
    end
  end

endmodule

// File: tb/tb_l2_home_responder.sv
// Scoreboard bench for l2_home_responder: expected responses are queued at request
// time from a small line-store model and popped when the DUT responds.
module tb_l2_home_responder;
  import l2_home_pkg::*;

  localparam int DEPTH_BITS = 6;
  localparam int LATENCY    = 4;
  localparam int ENTRIES    = 1 << DEPTH_BITS;

  typedef struct {
    mix_msg_t                   msg;
    line_addr_t                 addr;
    logic [`BITS_PER_LINE-1:0]  line;
    logic [`WORDS_PER_LINE-1:0] mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_unsupported;
  logic [15:0] rsp_count;
  int          cyc = 0;

  l2_home_responder_if bus();

  l2_home_responder #(.DEPTH_BITS(DEPTH_BITS), .LATENCY(LATENCY)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .err_unsupported (err_unsupported),
    .rsp_count       (rsp_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t                      sb[$];
  logic [`BITS_PER_LINE-1:0] model [ENTRIES];
  int                        total = 0;
  int                        bad = 0;
  logic [15:0]               exp_count = '0;
  int                        acc_cyc = 0;

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) model[i] = '0;
  endtask

  // Drive one request, wait for acceptance and queue its expected response.
  task automatic send(input mix_msg_t msg, input line_addr_t addr,
                      input logic [`BITS_PER_LINE-1:0] line, input logic [3:0] mask);
    int n = 0;
    logic [DEPTH_BITS-1:0] i;
    exp_t e;
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_coh_msg   = msg;
    bus.req_hprot     = 2'b01;
    bus.req_addr      = addr;
    bus.req_line      = line;
    bus.req_word_mask = mask;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got req_ready=0 exp req_ready=1");
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acc_cyc       = cyc;
    bus.req_valid = 1'b0;
    i = addr[DEPTH_BITS-1:0];
    e.addr = addr;
    e.mask = mask;
    e.line = model[i];
    case (msg)
      REQ_V:     begin e.msg = RSP_V;     sb.push_back(e); end
      REQ_S:     begin e.msg = RSP_S;     sb.push_back(e); end
      REQ_O:     begin e.msg = RSP_O;     sb.push_back(e); end
      REQ_ODATA: begin e.msg = RSP_ODATA; sb.push_back(e); end
      REQ_WT, REQ_WB: begin
        e.msg  = (msg == REQ_WT) ? RSP_WT : RSP_WB_ACK;
        e.line = '0;
        sb.push_back(e);
        for (int w = 0; w < `WORDS_PER_LINE; w++)
          if (mask[w]) model[i][w*32 +: 32] = line[w*32 +: 32];
      end
      default: ;
    endcase
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall it.
  task automatic get_rsp(input int stall);
    int n = 0;
    exp_t e;
    bus.rsp_ready = (stall == 0);
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!bus.rsp_valid) begin
      bad++;
      $display("FAIL rsp_timeout got rsp_valid=0 exp rsp_valid=1");
      return;
    end else if (cyc - acc_cyc != LATENCY) begin
      bad++;
      $display("FAIL rsp_latency got=%0d exp=%0d", cyc - acc_cyc, LATENCY);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL rsp_unexpected got rsp_valid=1 exp no response");
      return;
    end
    e = sb.pop_front();
    total++;
    if (bus.rsp_coh_msg !== e.msg) begin
      bad++; $display("FAIL rsp_coh_msg got=%h exp=%h", bus.rsp_coh_msg, e.msg);
    end
    total++;
    if (bus.rsp_addr !== e.addr) begin
      bad++; $display("FAIL rsp_addr got=%h exp=%h", bus.rsp_addr, e.addr);
    end
    total++;
    if (bus.rsp_line !== e.line) begin
      bad++; $display("FAIL rsp_line got=%h exp=%h", bus.rsp_line, e.line);
    end
    total++;
    if (bus.rsp_word_mask !== e.mask || bus.rsp_invack_cnt !== '0) begin
      bad++;
      $display("FAIL rsp_mask_invack got=%b/%0d exp=%b/0", bus.rsp_word_mask,
               bus.rsp_invack_cnt, e.mask);
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      total++;
      if (!bus.rsp_valid || bus.req_ready || bus.rsp_coh_msg !== e.msg ||
          bus.rsp_addr !== e.addr || bus.rsp_line !== e.line || bus.rsp_word_mask !== e.mask) begin
        bad++;
        $display("FAIL stall_hold cycle=%0d got valid=%b ready=%b msg=%h addr=%h exp valid=1 ready=0 msg=%h addr=%h",
                 k, bus.rsp_valid, bus.req_ready, bus.rsp_coh_msg, bus.rsp_addr, e.msg, e.addr);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || rsp_count !== exp_count) begin
      bad++;
      $display("FAIL post_handshake got valid=%b ready=%b count=%0d exp valid=0 ready=1 count=%0d",
               bus.rsp_valid, bus.req_ready, rsp_count, exp_count);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int early = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || err_unsupported !== 1'b0 ||
        rsp_count !== 16'd0 || bus.rsp_line !== '0 || bus.rsp_addr !== '0 ||
        bus.rsp_coh_msg !== '0 || bus.rsp_word_mask !== '0) begin
      bad++;
      $display("FAIL reset_values got ready=%b valid=%b err=%b count=%0d exp all 0",
               bus.req_ready, bus.rsp_valid, err_unsupported, rsp_count);
    end
    rst = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || err_unsupported !== 1'b0) early++;
      @(negedge clk);
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL init_window got bad_cycles=%0d exp 0", early);
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL init_done got req_ready=%b exp 1", bus.req_ready);
    end
  endtask

  task automatic test_write_read();
    send(REQ_WT, 26'h12, {16{8'hA5}}, 4'b1111);
    get_rsp(0);
    send(REQ_V, 26'h12, '0, 4'b1111);
    get_rsp(0);
  endtask

  task automatic test_partial_merge();
    send(REQ_WB, 26'h03, {32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF}, 4'b0001);
    get_rsp(0);
    send(REQ_S, 26'h03, '0, 4'b1111);
    get_rsp(0);
    send(REQ_V, 26'h43, '0, 4'b1111);
    get_rsp(0);
    send(REQ_ODATA, 26'h03, '0, 4'b0110);
    get_rsp(0);
  endtask

  task automatic test_backpressure();
    send(REQ_O, 26'h12, '0, 4'b1010);
    get_rsp(10);
  endtask

  task automatic test_unsupported();
    int seen = 0;
    send(5'h1F, 26'h05, {4{32'hFFFF0000}}, 4'b1111);
    bus.rsp_ready = 1'b1;
    repeat (LATENCY + 6) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    bus.rsp_ready = 1'b0;
    total++;
    if (seen != 0 || err_unsupported !== 1'b1 || rsp_count !== exp_count) begin
      bad++;
      $display("FAIL unsupported got rsp_cycles=%0d err=%b count=%0d exp 0/1/%0d",
               seen, err_unsupported, rsp_count, exp_count);
    end
    send(REQ_V, 26'h05, '0, 4'b1111);
    get_rsp(0);
    total++;
    if (err_unsupported !== 1'b1) begin
      bad++; $display("FAIL err_sticky got=%b exp=1", err_unsupported);
    end
  endtask

  task automatic test_reset_mid_response();
    int n = 0;
    send(REQ_V, 26'h03, '0, 4'b1111);
    bus.rsp_ready = 1'b0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_clear();
    exp_count = '0;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0 || rsp_count !== 16'd0 ||
        err_unsupported !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got valid=%b ready=%b count=%0d err=%b exp 0/0/0/0",
               bus.rsp_valid, bus.req_ready, rsp_count, err_unsupported);
    end
    n = 0;
    while (!bus.req_ready && n < ENTRIES + 5) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != ENTRIES) begin
      bad++; $display("FAIL reinit_len got=%0d exp=%0d", n, ENTRIES);
    end
    send(REQ_V, 26'h12, '0, 4'b1111);
    get_rsp(0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_coh_msg   = '0;
    bus.req_hprot     = '0;
    bus.req_addr      = '0;
    bus.req_line      = '0;
    bus.req_word_mask = '0;
    bus.rsp_ready     = 1'b0;
    model_clear();
    test_reset();
    test_write_read();
    test_partial_merge();
    test_backpressure();
    test_unsupported();
    test_reset_mid_response();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
